lfsr_addr_gen: RTL and testbench
================================

// Module: lfsr_addr_gen
// PURPOSE
//  14-bit maximal-length Fibonacci LFSR that generates the pseudo-random address stream consumed by comp_unit.
//  q[13] drives comp_unit Q1 and q[0] drives Q14.
//  Valid/ready output handshake; seed load, start/stop control, zero-lockup guard, optional period check.
// PARAMETERS
//  W     14        LFSR width in bits
//  TAPS  14'h3802  feedback mask (x^14+x^13+x^12+x^2+1)
//  SEED  14'h0001  reset value of q; must be non-zero
// PORTS
//  clk          in   1  single clock, rising edge
//  rst_n        in   1  asynchronous, active-low reset
//  start        in   1  IDLE->RUN request (level or pulse)
//  stop         in   1  RUN->IDLE request
//  load         in   1  load seed_in into q; accepted in IDLE only
//  seed_in      in   W  seed value
//  one_shot     in   1  1: stop after one full period (PERIOD_CHK only)
//  out_ready    in   1  downstream accepts q
//  out_valid    out  1  q is a valid address
//  q            out  W  current LFSR state
//  lockup       out  1  sticky: a zero seed was forced to 1
//  period_done  out  1  one-cycle pulse when a full period has been emitted
//  busy         out  1  FSM is not in IDLE
// BEHAVIOUR
//  Reset: q=SEED, out_valid=0, lockup=0, period_done=0, busy=0, FSM=IDLE, count=0.
//  Next state: q_nxt = {q[W-2:0], ^(q & TAPS)}. Period is 2^W-1; state 0 is never reachable.
//  FSM states:
//   IDLE->RUN: on start && !stop; out_valid rises the next cycle, with q unchanged (first output = seed).
//   RUN: a handshake is out_valid && out_ready; q <= q_nxt on each handshake.
//   DONE: out_valid=0; DONE->IDLE on start (or load).
//  Handshake rules:
//   While out_valid && !out_ready, q and out_valid hold stable.
//   out_ready with out_valid=0 has no effect.
//  Stop:
//   stop in RUN sets stop_pend. The FSM goes to IDLE after the next handshake, or at once if out_valid=0.
//   out_valid never drops without a handshake.
//  IDLE control:
//   start && stop together: stop wins; FSM stays in IDLE.
//   load in IDLE: q<=seed_in next cycle; load has priority over start in the same cycle.
//   load outside IDLE is ignored.
//   seed_in==0: q<=1 and lockup<=1 (sticky until reset).
//  busy=1 in RUN and DONE.
//  Reset mid-operation: all registers return to reset values at once; out_valid drops asynchronously.
// CONFIGURATION
//  LFSR_PERIOD_CHK_EN defined:
//   W-bit count register; cleared on IDLE->RUN and on load; +1 per handshake.
//   The handshake that brings count to 2^W-1 gives period_done=1 the next cycle, and count wraps to 0.
//   At that point q equals the run's starting value.
//   If one_shot=1 at that handshake, the FSM goes to DONE instead of continuing.
//  Not defined: no count register; period_done tied to 0; one_shot ignored; the generator free-runs.
// TESTING
//  1. Reset, start, ready=1 -> out_valid rises 1 cycle after start; q=0001,0002,0005,000A,0015.
//  2. In RUN, hold ready=0 for 5 cycles -> q and out_valid stable; ready=1 -> advances exactly one step per cycle.
//  3. load with seed_in=0 in IDLE -> q=0001, lockup=1 until rst_n is asserted; load in RUN -> q unaffected.
//  4. stop while valid && !ready -> out_valid stays 1; one handshake, then IDLE with busy=0.
//     start+stop in IDLE -> stays IDLE.
//  5. PERIOD_CHK, ready=1, one_shot=1 -> period_done pulse after 16383 handshakes; q back to seed; FSM=DONE.
//     All 16383 non-zero values seen once.
//  6. Assert rst_n=0 mid-RUN while valid -> out_valid=0 immediately; q=SEED; FSM=IDLE; lockup=0.

Source files
------------

// File: rtl/lfsr_addr_gen.sv
// lfsr_addr_gen: 14-bit Fibonacci LFSR address generator with a valid/ready output handshake.
// Optional period counter, period_done pulse and one_shot stop are enabled by LFSR_PERIOD_CHK_EN.
module lfsr_addr_gen #(
  parameter int unsigned  W    = 14,
  parameter logic [W-1:0] TAPS = 14'h3802,
  parameter logic [W-1:0] SEED = 14'h0001
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         stop,
  input  logic         load,
  input  logic [W-1:0] seed_in,
  input  logic         one_shot,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] q,
  output logic         lockup,
  output logic         period_done,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  state_t       state, state_nxt;
  logic         stop_pend, stop_pend_nxt;
  logic         handshake, launch, load_ok, period_stop;
  logic [W-1:0] lfsr_nxt;

  // out_valid is a decode of the state register, so it drops with the async reset.
  assign out_valid = (state == RUN);
  assign busy      = (state != IDLE);
  assign handshake = out_valid && out_ready;
  assign load_ok   = (state == IDLE) && load;
  assign launch    = (state == IDLE) && !load && start && !stop;
  assign lfsr_nxt  = {q[W-2:0], ^(q & TAPS)};

`ifdef LFSR_PERIOD_CHK_EN
  localparam logic [W-1:0] LAST = {{(W-1){1'b1}}, 1'b0};

  logic [W-1:0] count;
  logic         wrap;

  // The handshake taking count to 2^W-1 closes the period; count wraps straight to 0.
  assign wrap        = handshake && (count == LAST);
  assign period_stop = wrap && one_shot;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count       <= '0;
      period_done <= 1'b0;
    end else begin
      period_done <= wrap;
      if (launch || load_ok || wrap) count <= '0;
      else if (handshake)            count <= count + ONE;
    end
  end
`else
  logic unused_one_shot;

  assign unused_one_shot = one_shot;
  assign period_stop     = 1'b0;
  assign period_done     = 1'b0;
`endif

  // NOTE: every always_comb output gets a default before the case so no latch is inferred.
  always_comb begin
    state_nxt     = state;
    stop_pend_nxt = 1'b0;
    case (state)
      IDLE: if (launch) state_nxt = RUN;
      RUN: begin
        // A pending stop waits for a handshake so out_valid never drops unaccepted.
        stop_pend_nxt = (stop || stop_pend) && !handshake;
        if (period_stop)                          state_nxt = DONE;
        else if (handshake && (stop || stop_pend)) state_nxt = IDLE;
      end
      DONE:    if (start || load) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      stop_pend <= 1'b0;
      q         <= SEED;
      lockup    <= 1'b0;
    end else begin
      state     <= state_nxt;
      stop_pend <= stop_pend_nxt;
      if (load_ok) begin
        // Zero is the lock-up state of the LFSR; substitute 1 and flag it until reset.
        if (seed_in == '0) begin
          q      <= ONE;
          lockup <= 1'b1;
        end else begin
          q <= seed_in;
        end
      end else if (handshake) begin
        q <= lfsr_nxt;
      end
    end
  end

endmodule

// File: tb/tb_lfsr_addr_gen.sv
// tb_lfsr_addr_gen: randomized self-checking bench for lfsr_addr_gen against a cyclic-sequence model.
// Builds with or without LFSR_PERIOD_CHK_EN; the period scenario follows the build.
module tb_lfsr_addr_gen;

  localparam int W = 14;
  localparam int N = (1 << W) - 1;
  localparam logic [W-1:0] SEED = 14'h0001;
  localparam logic [W-1:0] TAPS = 14'h3802;

  logic         clk = 1'b0;
  logic         rst_n, start, stop, load, one_shot, out_ready;
  logic [W-1:0] seed_in, q;
  logic         out_valid, lockup, period_done, busy;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference: the whole maximal-length cycle as a table, plus each value's position in it.
  logic [W-1:0] seq [N];
  int           pos [1 << W];
  int           idx;

  always #5 clk = ~clk;

  lfsr_addr_gen #(.W(W), .TAPS(TAPS), .SEED(SEED)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .load(load),
    .seed_in(seed_in), .one_shot(one_shot), .out_ready(out_ready),
    .out_valid(out_valid), .q(q), .lockup(lockup),
    .period_done(period_done), .busy(busy)
  );

  function automatic logic [W-1:0] ref_next(input logic [W-1:0] v);
    int unsigned nv = ((int'(v) * 2) % (1 << W)) + ($countones(v & TAPS) % 2);
    return nv[W-1:0];
  endfunction

  task automatic build_model();
    logic [W-1:0] v = SEED;
    for (int i = 0; i < (1 << W); i++) pos[i] = -1;
    for (int i = 0; i < N; i++) begin
      seq[i] = v;
      pos[v] = i;
      v      = ref_next(v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (q !== SEED || out_valid !== 1'b0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL reset_state: q=%h valid=%b busy=%b, want q=%h valid=0 busy=0", q, out_valid, busy, SEED);
    end
    n_cmp++; if (lockup !== 1'b0 || period_done !== 1'b0) begin
      n_bad++; $display("FAIL reset_flags: lockup=%b period_done=%b, want 0 0", lockup, period_done);
    end
    rst_n = 1'b1;
    tick();
    n_cmp++; if (q !== SEED || out_valid !== 1'b0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL idle_after_reset: q=%h valid=%b busy=%b", q, out_valid, busy);
    end
  endtask

  task automatic test_sequence();
    logic [W-1:0] golden [5];
    golden = '{14'h0001, 14'h0002, 14'h0005, 14'h000A, 14'h0015};
    out_ready = 1'b1;
    start     = 1'b1;
    tick();
    start = 1'b0;
    n_cmp++; if (out_valid !== 1'b1 || busy !== 1'b1) begin
      n_bad++; $display("FAIL valid_after_start: valid=%b busy=%b, want 1 1", out_valid, busy);
    end
    for (int k = 0; k < 5; k++) begin
      n_cmp++; if (q !== golden[k]) begin
        n_bad++; $display("FAIL first_outputs[%0d]: q=%h want %h", k, q, golden[k]);
      end
      tick();
    end
    idx = 5;
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      n_cmp++; if (q !== seq[idx] || out_valid !== 1'b1) begin
        n_bad++; $display("FAIL hold[%0d]: q=%h valid=%b, want q=%h valid=1", c, q, out_valid, seq[idx]);
      end
    end
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      idx = (idx + 1) % N;
      n_cmp++; if (q !== seq[idx]) begin
        n_bad++; $display("FAIL resume[%0d]: q=%h want %h", c, q, seq[idx]);
      end
    end
  endtask

  task automatic test_random_ready();
    int errs = 0;
    for (int c = 0; c < 300; c++) begin
      bit r = 1'($urandom_range(0, 1));
      out_ready = r;
      tick();
      if (r) idx = (idx + 1) % N;
      if (q !== seq[idx] || out_valid !== 1'b1) begin
        if (errs == 0) $display("FAIL random_ready[%0d]: q=%h valid=%b, want q=%h valid=1", c, q, out_valid, seq[idx]);
        errs++;
      end
    end
    n_cmp++; if (errs != 0) n_bad++;
  endtask

  task automatic test_stop();
    out_ready = 1'b0;
    stop      = 1'b1;
    tick();
    stop = 1'b0;
    n_cmp++; if (out_valid !== 1'b1 || busy !== 1'b1 || q !== seq[idx]) begin
      n_bad++; $display("FAIL stop_pending: valid=%b busy=%b q=%h, want 1 1 %h", out_valid, busy, q, seq[idx]);
    end
    tick();
    n_cmp++; if (out_valid !== 1'b1) begin
      n_bad++; $display("FAIL stop_holds_valid: valid=%b want 1", out_valid);
    end
    out_ready = 1'b1;
    tick();
    idx = (idx + 1) % N;
    n_cmp++; if (out_valid !== 1'b0 || busy !== 1'b0 || q !== seq[idx]) begin
      n_bad++; $display("FAIL stop_to_idle: valid=%b busy=%b q=%h, want 0 0 %h", out_valid, busy, q, seq[idx]);
    end
    tick();
    n_cmp++; if (q !== seq[idx]) begin
      n_bad++; $display("FAIL ready_without_valid: q=%h want %h", q, seq[idx]);
    end
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    n_cmp++; if (busy !== 1'b0 || out_valid !== 1'b0) begin
      n_bad++; $display("FAIL start_stop_idle: busy=%b valid=%b, want 0 0", busy, out_valid);
    end
    tick();
    n_cmp++; if (busy !== 1'b0 || out_valid !== 1'b0) begin
      n_bad++; $display("FAIL start_stop_idle_late: busy=%b valid=%b, want 0 0", busy, out_valid);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_load();
    logic [W-1:0] s = W'($urandom_range(1, N));
    seed_in = s;
    load    = 1'b1;
    start   = 1'b1;
    tick();
    load  = 1'b0;
    start = 1'b0;
    n_cmp++; if (q !== s || busy !== 1'b0 || lockup !== 1'b0) begin
      n_bad++; $display("FAIL load_over_start: q=%h busy=%b lockup=%b, want %h 0 0", q, busy, lockup, s);
    end
    seed_in = '0;
    load    = 1'b1;
    tick();
    load = 1'b0;
    n_cmp++; if (q !== 14'h0001 || lockup !== 1'b1) begin
      n_bad++; $display("FAIL zero_seed: q=%h lockup=%b, want 0001 1", q, lockup);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    n_cmp++; if (out_valid !== 1'b1 || q !== 14'h0001) begin
      n_bad++; $display("FAIL start_after_zero_seed: valid=%b q=%h, want 1 0001", out_valid, q);
    end
    seed_in = W'($urandom_range(2, N));
    load    = 1'b1;
    tick();
    load = 1'b0;
    n_cmp++; if (q !== 14'h0001 || busy !== 1'b1) begin
      n_bad++; $display("FAIL load_in_run: q=%h busy=%b, want 0001 1", q, busy);
    end
    stop = 1'b1;
    tick();
    stop      = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    idx = (pos[14'h0001] + 1) % N;
    n_cmp++; if (busy !== 1'b0 || q !== seq[idx] || lockup !== 1'b1) begin
      n_bad++; $display("FAIL lockup_sticky: busy=%b q=%h lockup=%b, want 0 %h 1", busy, q, lockup, seq[idx]);
    end
  endtask

`ifdef LFSR_PERIOD_CHK_EN
  task automatic test_period();
    logic [W-1:0] s = W'($urandom_range(1, N));
    bit seen [1 << W];
    int p, seq_err = 0, early = 0, distinct = 0;
    seed_in = s;
    load    = 1'b1;
    tick();
    load      = 1'b0;
    one_shot  = 1'b1;
    out_ready = 1'b1;
    start     = 1'b1;
    tick();
    start = 1'b0;
    p = pos[s];
    for (int h = 0; h < N; h++) begin
      if (q !== seq[(p + h) % N]) seq_err++;
      if (period_done !== 1'b0 || out_valid !== 1'b1) early++;
      seen[q] = 1'b1;
      tick();
    end
    for (int v = 1; v < (1 << W); v++) if (seen[v]) distinct++;
    n_cmp++; if (seq_err != 0) begin
      n_bad++; $display("FAIL period_sequence: %0d wrong outputs, want 0", seq_err);
    end
    n_cmp++; if (early != 0) begin
      n_bad++; $display("FAIL period_early: %0d cycles with pulse or dropped valid, want 0", early);
    end
    n_cmp++; if (distinct != N || seen[0]) begin
      n_bad++; $display("FAIL period_coverage: %0d distinct non-zero values, zero_seen=%b, want %0d 0", distinct, seen[0], N);
    end
    n_cmp++; if (period_done !== 1'b1 || q !== s || out_valid !== 1'b0 || busy !== 1'b1) begin
      n_bad++; $display("FAIL period_done: pulse=%b q=%h valid=%b busy=%b, want 1 %h 0 1", period_done, q, out_valid, busy, s);
    end
    tick();
    n_cmp++; if (period_done !== 1'b0 || busy !== 1'b1 || q !== s) begin
      n_bad++; $display("FAIL done_hold: pulse=%b busy=%b q=%h, want 0 1 %h", period_done, busy, q, s);
    end
    seed_in = ~s;
    load    = 1'b1;
    tick();
    load      = 1'b0;
    one_shot  = 1'b0;
    out_ready = 1'b0;
    n_cmp++; if (busy !== 1'b0 || q !== s) begin
      n_bad++; $display("FAIL done_load_to_idle: busy=%b q=%h, want 0 %h", busy, q, s);
    end
  endtask
`else
  task automatic test_period();
    int seq_err = 0, bad_flag = 0;
    one_shot  = 1'b1;
    out_ready = 1'b1;
    start     = 1'b1;
    tick();
    start = 1'b0;
    for (int h = 0; h < N + 20; h++) begin
      if (q !== seq[idx]) seq_err++;
      if (period_done !== 1'b0 || out_valid !== 1'b1) bad_flag++;
      tick();
      idx = (idx + 1) % N;
    end
    n_cmp++; if (seq_err != 0) begin
      n_bad++; $display("FAIL free_run_sequence: %0d wrong outputs, want 0", seq_err);
    end
    n_cmp++; if (bad_flag != 0) begin
      n_bad++; $display("FAIL free_run_flags: %0d cycles with pulse or dropped valid, want 0", bad_flag);
    end
    out_ready = 1'b0;
    stop      = 1'b1;
    tick();
    stop      = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    one_shot  = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin
      n_bad++; $display("FAIL free_run_stop: busy=%b want 0", busy);
    end
  endtask
`endif

  task automatic test_async_reset();
    n_cmp++; if (lockup !== 1'b1) begin
      n_bad++; $display("FAIL lockup_before_reset: lockup=%b want 1", lockup);
    end
    out_ready = 1'b0;
    start     = 1'b1;
    tick();
    start = 1'b0;
    n_cmp++; if (out_valid !== 1'b1) begin
      n_bad++; $display("FAIL run_before_reset: valid=%b want 1", out_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0 || busy !== 1'b0 || q !== SEED) begin
      n_bad++; $display("FAIL async_reset: valid=%b busy=%b q=%h, want 0 0 %h", out_valid, busy, q, SEED);
    end
    n_cmp++; if (lockup !== 1'b0 || period_done !== 1'b0) begin
      n_bad++; $display("FAIL async_reset_flags: lockup=%b period_done=%b, want 0 0", lockup, period_done);
    end
    #2 rst_n = 1'b1;
    tick();
    n_cmp++; if (out_valid !== 1'b0 || q !== SEED) begin
      n_bad++; $display("FAIL after_async_reset: valid=%b q=%h, want 0 %h", out_valid, q, SEED);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    stop      = 1'b0;
    load      = 1'b0;
    one_shot  = 1'b0;
    out_ready = 1'b0;
    seed_in   = '0;
    build_model();
    test_reset();
    test_sequence();
    test_backpressure();
    test_random_ready();
    test_stop();
    test_load();
    test_period();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached after %0d comparisons", n_cmp);
    $fatal(1, "watchdog expired");
  end

endmodule
